// File: rtl/alu_cmd_driver.sv
// Command-queued driver for the 8-bit combinational ALU: buffers commands, holds ALU inputs for a
// settle time, captures result/carry into a valid/ready response and keeps a chaining accumulator.
module alu_cmd_driver #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_use_acc,
  input  logic             acc_clr,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [3:0]  OpDiv = 4'b0011;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e            state_q, state_d;
  cmd_t              mem_q [FIFO_DEPTH];
  cmd_t              mem_d [FIFO_DEPTH];
  cmd_t              cmd_in, head;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     cnt_q, cnt_d;
  logic              full, empty, push, pop, div_zero;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [7:0]        alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]        alu_sel_q, alu_sel_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_carry_q, rsp_carry_d;
  logic              rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic [7:0]        rsp_data_q, rsp_data_d, acc_q, acc_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  assign cmd_in   = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
  assign head     = mem_q[rd_ptr_q];
  assign full     = (cnt_q == (PtrW+1)'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = cmd_valid && !full;
  assign div_zero = (head.op == OpDiv) && (head.b == 8'd0);

  // Command FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = cmd_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = div_zero ? StResp : StDrive;
      StDrive: if (settle_q == '0) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: FIFO pop and datapath register updates
  always_comb begin
    pop         = 1'b0;
    settle_d    = settle_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    acc_d       = acc_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          if (div_zero) begin
            // Rejected divide: ALU inputs are left untouched so it never sees B == 0.
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'hFF;
            rsp_carry_d = 1'b0;
            rsp_zero_d  = 1'b0;
            rsp_err_d   = 1'b1;
          end else begin
            alu_sel_d = head.op;
            alu_b_d   = head.b;
            alu_a_d   = head.use_acc ? acc_q : head.a;
            settle_d  = SetW'(SETTLE_CYCLES - 1);
          end
        end
      end
      StDrive: begin
        if (settle_q == '0) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_result;
          rsp_carry_d = alu_carry;
          rsp_zero_d  = (alu_result == 8'd0);
          rsp_err_d   = 1'b0;
          acc_d       = alu_result;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (acc_clr) acc_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      settle_q    <= settle_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign cmd_ready = !full;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;
  assign busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU, directed commands, response scoreboard with a
// decoupled monitor, plus direct checks of reset, backpressure, accumulator and counter wrap.
module tb_alu_cmd_driver;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready, cmd_use_acc, acc_clr;
  logic [3:0]      cmd_op, alu_sel;
  logic [7:0]      cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_data, acc;
  logic            alu_carry, rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_err, busy;
  logic [CntW-1:0] op_count;

  int              n_vec  = 0;
  int              n_miss = 0;
  logic [10:0]     sb [$];
  logic [10:0]     mon_got, mon_want;
  logic [8:0]      alu_wide;
  logic [15:0]     alu_prod;
  logic [5:0]      rdy_vec;
  int              rdy_at;

  logic [3:0]      bp_op [6] = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h2, 4'h0};
  logic [7:0]      bp_a  [6] = '{8'd100, 8'd5, 8'd200, 8'd7, 8'd16, 8'd1};
  logic [7:0]      bp_b  [6] = '{8'd50, 8'd7, 8'd100, 8'd7, 8'd17, 8'd1};
  logic [10:0]     bp_exp[5] = '{{8'd150, 3'b000}, {8'hFE, 3'b100}, {8'd44, 3'b100},
                                 {8'd0, 3'b010}, {8'd16, 3'b100}};

  alu_cmd_driver #(
    .FIFO_DEPTH   (4),
    .SETTLE_CYCLES(1),
    .CNT_W        (CntW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .acc_clr    (acc_clr),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .acc        (acc),
    .op_count   (op_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, subtract (carry = borrow), multiply (carry = high byte set), divide
  always_comb begin
    alu_wide   = '0;
    alu_prod   = '0;
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_sel)
      4'b0000: begin
        alu_wide   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_wide[7:0];
        alu_carry  = alu_wide[8];
      end
      4'b0001: begin
        alu_wide   = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_wide[7:0];
        alu_carry  = alu_wide[8];
      end
      4'b0010: begin
        alu_prod   = 16'(alu_a) * 16'(alu_b);
        alu_result = alu_prod[7:0];
        alu_carry  = |alu_prod[15:8];
      end
      4'b0011: alu_result = (alu_b == 8'd0) ? 8'hFF : alu_a / alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  function automatic logic [10:0] rsp(input logic [7:0] d, input logic c, input logic z,
                                      input logic e);
    return {d, c, z, e};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_miss++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  // Enqueue one command; queue an expected response when the command should produce one.
  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc, input logic expect_rsp, input logic [10:0] exp);
    bit ok;
    ok          = 1'b0;
    cmd_op      = op;
    cmd_a       = a;
    cmd_b       = b;
    cmd_use_acc = use_acc;
    cmd_valid   = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    if (!ok) timeout("push_cmd_ready");
    else if (expect_rsp) sb.push_back(exp);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) ok = 1'b1;
    end
    if (!ok) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_a       = '0;
    cmd_b       = '0;
    cmd_use_acc = 1'b0;
    acc_clr     = 1'b0;
    rsp_ready   = 1'b1;

    // Monitor: every accepted response is checked against the scoreboard head.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
          mon_got = {rsp_data, rsp_carry, rsp_zero, rsp_err};
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL rsp_unexpected: got %0h expected no response", mon_got);
          end else begin
            mon_want = sb.pop_front();
            check("rsp {data,carry,zero,err}", 64'(mon_got), 64'(mon_want));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset_outputs", 64'({alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero,
                                 rsp_err, acc, op_count, busy}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add: operands registered one cycle after the push edge
    push_cmd(4'h0, 8'd3, 8'd5, 1'b0, 1'b1, rsp(8'd8, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("add_alu_inputs", 64'({alu_a, alu_b, alu_sel}), 64'({8'd3, 8'd5, 4'h0}));
    wait_idle();
    check("add_acc", 64'(acc), 64'(8));
    check("add_op_count", 64'(op_count), 64'(1));

    // Chained operations through the accumulator
    push_cmd(4'h0, 8'd10, 8'd20, 1'b0, 1'b1, rsp(8'd30, 1'b0, 1'b0, 1'b0));
    push_cmd(4'h1, 8'd99, 8'd5, 1'b1, 1'b1, rsp(8'd25, 1'b0, 1'b0, 1'b0));
    push_cmd(4'h2, 8'd99, 8'd2, 1'b1, 1'b1, rsp(8'd50, 1'b0, 1'b0, 1'b0));
    wait_idle();
    check("chain_acc", 64'(acc), 64'(50));
    check("chain_op_count", 64'(op_count), 64'(4));

    // Divide by zero is rejected without touching the ALU or the accumulator
    push_cmd(4'h3, 8'd9, 8'd0, 1'b0, 1'b1, rsp(8'hFF, 1'b0, 1'b0, 1'b1));
    wait_idle();
    check("div0_alu_held", 64'({alu_a, alu_b, alu_sel}), 64'({8'd25, 8'd2, 4'h2}));
    check("div0_acc", 64'(acc), 64'(50));
    push_cmd(4'h3, 8'd9, 8'd3, 1'b0, 1'b1, rsp(8'd3, 1'b0, 1'b0, 1'b0));
    wait_idle();
    check("div_acc", 64'(acc), 64'(3));
    check("div_op_count", 64'(op_count), 64'(6));

    // Backpressure: 6 back-to-back offers, 5 fit (4 queued + 1 in flight)
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_op      = bp_op[i];
      cmd_a       = bp_a[i];
      cmd_b       = bp_b[i];
      cmd_use_acc = 1'b0;
      cmd_valid   = 1'b1;
      if (i < 5) sb.push_back(bp_exp[i]);
      @(negedge clk);
      rdy_vec[i] = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("bp_cmd_ready_pattern", 64'(rdy_vec), 64'(6'b011111));
    check("bp_rsp_first", 64'({rsp_valid, rsp_data}), 64'({1'b1, 8'd150}));
    repeat (3) @(posedge clk);
    #1;
    check("bp_rsp_stable", 64'({rsp_valid, rsp_data, rsp_carry}), 64'({1'b1, 8'd150, 1'b0}));
    check("bp_still_full", 64'(cmd_ready), 64'(0));
    rsp_ready = 1'b1;
    rdy_at    = -1;
    for (int k = 0; k < 10 && rdy_at < 0; k++) begin
      @(negedge clk);
      if (cmd_ready) rdy_at = k;
    end
    check("bp_ready_return_cycle", 64'(rdy_at), 64'(2));
    wait_idle();
    check("bp_op_count", 64'(op_count), 64'(11));
    check("bp_acc", 64'(acc), 64'(16));

    // Reset while driving with two commands still queued
    rsp_ready = 1'b0;
    push_cmd(4'h0, 8'd1, 8'd2, 1'b0, 1'b1, rsp(8'd3, 1'b0, 1'b0, 1'b0));
    push_cmd(4'h1, 8'd9, 8'd4, 1'b0, 1'b0, '0);
    push_cmd(4'h0, 8'd11, 8'd11, 1'b0, 1'b0, '0);
    push_cmd(4'h0, 8'd12, 8'd12, 1'b0, 1'b0, '0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_drive", 64'({alu_a, alu_b, alu_sel, busy}), 64'({8'd9, 8'd4, 4'h1, 1'b1}));
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry,
                                    rsp_zero, rsp_err, acc, op_count, busy}), 64'(0));
    check("midreset_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_quiet", 64'({busy, rsp_valid}), 64'(0));
    push_cmd(4'h0, 8'd3, 8'd4, 1'b0, 1'b1, rsp(8'd7, 1'b0, 1'b0, 1'b0));
    wait_idle();
    check("post_reset_acc_count", 64'({acc, op_count}), 64'({8'd7, 4'd1}));

    // acc_clr on the capture edge wins over the result write
    push_cmd(4'h0, 8'd2, 8'd3, 1'b0, 1'b1, rsp(8'd5, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("accclr_acc", 64'(acc), 64'(0));
    check("accclr_rsp", 64'({rsp_valid, rsp_data}), 64'({1'b1, 8'd5}));
    wait_idle();
    check("accclr_op_count", 64'(op_count), 64'(2));

    // Counter wrap: 14 more operations bring the 4-bit count from 2 back to 0
    for (int i = 0; i < 14; i++) begin
      push_cmd(4'h0, 8'(i), 8'd1, 1'b0, 1'b1, rsp(8'(i + 1), 1'b0, 1'b0, 1'b0));
      wait_idle();
      if (i == 12) check("wrap_count_15", 64'(op_count), 64'(15));
    end
    check("wrap_count_0", 64'(op_count), 64'(0));
    check("wrap_acc", 64'(acc), 64'(14));

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
